// File: rtl/ddr4_v2_2_20_axi_ctrl_write.sv
// AXI4-Lite write-channel front end for the DDR4 control slave.
// Captures AW/W in any order, strobes the register file, returns B.
module ddr4_v2_2_20_axi_ctrl_write #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_REG          = 5,
  parameter int C_NUM_REG_WIDTH    = 3
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   axaddr,
  input  logic [C_NUM_REG_WIDTH-1:0]      reg_decode_num,
  output logic [C_NUM_REG-1:0]            reg_wr_en,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg_wr_data,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] reg_wr_strb
);

  typedef enum logic [1:0] {
    SM_IDLE,
    SM_WRITE,
    SM_RESP
  } state_t;

  state_t                     state;
  logic                       aw_held;
  logic                       w_held;
  logic                       areset_q;
  logic [C_NUM_REG_WIDTH-1:0] idx_q;
  logic                       aw_hs;
  logic                       w_hs;

  assign s_axi_awready = (state == SM_IDLE) & ~aw_held & ~areset_q;
  assign s_axi_wready  = (state == SM_IDLE) & ~w_held & ~areset_q;
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;

  // Delayed reset keeps ready low for one cycle after reset release.
  always_ff @(posedge aclk) begin
    areset_q <= areset;
  end

  // Beat capture, decode latch, strobe sequencing and B response.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= SM_IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      idx_q        <= '0;
      axaddr       <= '0;
      reg_wr_data  <= '0;
      reg_wr_strb  <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= 2'b00;
    end else begin
      unique case (state)
        SM_IDLE: begin
          if (aw_hs) begin
            axaddr  <= s_axi_awaddr;
            aw_held <= 1'b1;
          end
          if (w_hs) begin
            reg_wr_data <= s_axi_wdata;
            reg_wr_strb <= s_axi_wstrb;
            w_held      <= 1'b1;
          end
          if (aw_held & w_held) begin
            idx_q <= reg_decode_num;
            state <= SM_WRITE;
          end
        end
        SM_WRITE: begin
          s_axi_bresp  <= (idx_q != '0) ? 2'b00 : 2'b10;
          s_axi_bvalid <= 1'b1;
          aw_held      <= 1'b0;
          w_held       <= 1'b0;
          state        <= SM_RESP;
        end
        SM_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            state        <= SM_IDLE;
          end
        end
        default: state <= SM_IDLE;
      endcase
    end
  end

  // One-hot strobe, only while in the single write cycle.
  always_comb begin
    reg_wr_en = '0;
    if (state == SM_WRITE) begin
      for (int i = 1; i < C_NUM_REG; i++) begin
        if (idx_q == C_NUM_REG_WIDTH'(i)) reg_wr_en[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr4_v2_2_20_axi_ctrl_write.sv
// Self-checking bench for the AXI4-Lite write front end.
// Transaction-level model plus directed literal checks.
module tb_ddr4_v2_2_20_axi_ctrl_write;

  logic        clk;
  logic        areset;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] axaddr;
  logic [2:0]  reg_decode_num;
  logic [4:0]  reg_wr_en;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;

  int total = 0;
  int bad = 0;

  ddr4_v2_2_20_axi_ctrl_write dut (
    .aclk          (clk),
    .areset        (areset),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .axaddr        (axaddr),
    .reg_decode_num(reg_decode_num),
    .reg_wr_en     (reg_wr_en),
    .reg_wr_data   (reg_wr_data),
    .reg_wr_strb   (reg_wr_strb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register map: F000->1, F004->2, F008 read-only->0, F00C->4.
  function automatic logic [2:0] dec(input logic [31:0] a);
    if (a[31:4] != 28'h0000F00) return 3'd0;
    case (a[3:2])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      2'd2:    return 3'd0;
      default: return 3'd4;
    endcase
  endfunction

  always_comb reg_decode_num = dec(axaddr);

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  // transaction model state
  bit          m_prev_rst = 1'b1;
  bit          m_aw = 1'b0;
  bit          m_w = 1'b0;
  bit          m_busy = 1'b0;
  int          m_t = 0;
  logic [2:0]  m_idx = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_strb = '0;
  int          cyc = 0;

  // logs for literal checks
  logic [4:0]  pv[$];
  logic [31:0] pd[$];
  logic [3:0]  ps[$];
  logic [1:0]  bq[$];
  int          hs_q[$];
  int          bv_cnt = 0;
  int          stall_cnt = 0;
  int          consec = 0;
  logic [4:0]  prev_wr = '0;

  bit          e_raw;
  bit          e_rw;
  logic [4:0]  e_wr;
  bit          e_bv;

  always @(negedge clk) begin
    e_raw = !m_prev_rst && !m_busy && !m_aw;
    e_rw  = !m_prev_rst && !m_busy && !m_w;
    e_wr  = (m_busy && cyc == m_t + 2 && m_idx != 0) ? (5'b00001 << m_idx) : 5'b0;
    e_bv  = m_busy && cyc >= m_t + 3;
    chk("awready", s_axi_awready, e_raw);
    chk("wready", s_axi_wready, e_rw);
    chk("wr_en", reg_wr_en, e_wr);
    chk("bvalid", s_axi_bvalid, e_bv);
    if (e_bv) chk("bresp", s_axi_bresp, (m_idx != 0) ? 2'b00 : 2'b10);
    if (e_wr != 0) begin
      chk("wr_data", reg_wr_data, m_data);
      chk("wr_strb", reg_wr_strb, m_strb);
    end
    if (m_aw) chk("axaddr", axaddr, m_addr);
    if (reg_wr_en != 0) begin
      pv.push_back(reg_wr_en);
      pd.push_back(reg_wr_data);
      ps.push_back(reg_wr_strb);
      if (prev_wr != 0) consec++;
    end
    prev_wr = reg_wr_en;
    if (s_axi_bvalid) bv_cnt++;
    if (s_axi_bvalid && !s_axi_bready) stall_cnt++;
    if (s_axi_bvalid && s_axi_bready) bq.push_back(s_axi_bresp);
    if (s_axi_awvalid && s_axi_awready) hs_q.push_back(cyc);
    if (areset) begin
      m_aw = 1'b0;
      m_w = 1'b0;
      m_busy = 1'b0;
    end else begin
      if (s_axi_awvalid && e_raw) begin
        m_aw = 1'b1;
        m_addr = s_axi_awaddr;
      end
      if (s_axi_wvalid && e_rw) begin
        m_w = 1'b1;
        m_data = s_axi_wdata;
        m_strb = s_axi_wstrb;
      end
      if (!m_busy && m_aw && m_w) begin
        m_busy = 1'b1;
        m_t = cyc;
        m_idx = dec(m_addr);
      end else if (e_bv && s_axi_bready) begin
        m_busy = 1'b0;
        m_aw = 1'b0;
        m_w = 1'b0;
      end
    end
    m_prev_rst = areset;
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    pv.delete();
    pd.delete();
    ps.delete();
    bq.delete();
    hs_q.delete();
    bv_cnt = 0;
    stall_cnt = 0;
  endtask

  task automatic xfer(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int aw_at, input int w_at);
    bit ad = 1'b0;
    bit wd = 1'b0;
    int k = 0;
    while (!(ad && wd)) begin
      if (k >= 60) begin
        chk("xfer_timeout", 1'b1, 1'b0);
        break;
      end
      s_axi_awvalid = !ad && k >= aw_at;
      s_axi_awaddr  = a;
      s_axi_wvalid  = !wd && k >= w_at;
      s_axi_wdata   = d;
      s_axi_wstrb   = s;
      @(negedge clk);
      if (s_axi_awvalid && s_axi_awready) ad = 1'b1;
      if (s_axi_wvalid && s_axi_wready) wd = 1'b1;
      @(posedge clk);
      #1;
      k++;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
  endtask

  initial begin
    int k;
    areset = 1'b1;
    s_axi_awaddr = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata = '0;
    s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1;
    tick(3);
    areset = 1'b0;
    @(negedge clk);
    chk("rst_axaddr", axaddr, 32'h0);
    chk("rst_wdata", reg_wr_data, 32'h0);
    chk("rst_wstrb", reg_wr_strb, 4'h0);
    chk("rst_bresp", s_axi_bresp, 2'b00);
    chk("rst_bvalid", s_axi_bvalid, 1'b0);
    chk("rst_awready", s_axi_awready, 1'b0);
    tick(1);

    clr();
    xfer(32'h0000_F004, 32'hDEAD_BEEF, 4'hF, 0, 0);
    tick(8);
    chk("t1_npulse", pv.size(), 1);
    chk("t1_wr_en", pv[0], 5'b00100);
    chk("t1_data", pd[0], 32'hDEAD_BEEF);
    chk("t1_bresp", bq[0], 2'b00);
    chk("t1_bvcnt", bv_cnt, 1);

    clr();
    xfer(32'h0000_F00C, 32'h0BAD_CAFE, 4'hF, 3, 0);
    tick(8);
    chk("t2_wr_en", pv[0], 5'b10000);
    chk("t2_data", pd[0], 32'h0BAD_CAFE);
    chk("t2_bresp", bq[0], 2'b00);

    clr();
    xfer(32'h0000_F00C, 32'h1122_3344, 4'h3, 0, 3);
    tick(8);
    chk("t3_wr_en", pv[0], 5'b10000);
    chk("t3_strb", ps[0], 4'h3);

    clr();
    xfer(32'h0000_F008, 32'h5555_AAAA, 4'hF, 0, 0);
    tick(8);
    chk("t4_npulse", pv.size(), 0);
    chk("t4_bresp", bq[0], 2'b10);

    clr();
    xfer(32'h0000_F004, 32'h0000_0077, 4'h0, 0, 0);
    tick(8);
    chk("t5_wr_en", pv[0], 5'b00100);
    chk("t5_strb", ps[0], 4'h0);
    chk("t5_bresp", bq[0], 2'b00);

    clr();
    s_axi_bready = 1'b0;
    xfer(32'h0000_F004, 32'hA5A5_0001, 4'hF, 0, 0);
    k = 0;
    @(negedge clk);
    while (!s_axi_bvalid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("t6_bvalid_seen", s_axi_bvalid, 1'b1);
    fork
      begin
        repeat (10) @(posedge clk);
        #1;
        s_axi_bready = 1'b1;
      end
      xfer(32'h0000_F000, 32'hA5A5_0002, 4'hF, 0, 0);
    join
    tick(8);
    chk("t6_stall", stall_cnt, 10);
    chk("t6_npulse", pv.size(), 2);
    chk("t6_wr_en2", pv[1], 5'b00010);
    chk("t6_data2", pd[1], 32'hA5A5_0002);
    chk("t6_nresp", bq.size(), 2);

    clr();
    s_axi_wvalid = 1'b1;
    s_axi_wdata = 32'h1234_5678;
    s_axi_wstrb = 4'hF;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (s_axi_wready) break;
      @(posedge clk);
      #1;
      k++;
    end
    chk("t7_wcap", s_axi_wready, 1'b1);
    @(posedge clk);
    #1;
    s_axi_wvalid = 1'b0;
    areset = 1'b1;
    tick(1);
    areset = 1'b0;
    xfer(32'h0000_F000, 32'hCAFE_F00D, 4'hF, 0, 0);
    tick(8);
    chk("t7_npulse", pv.size(), 1);
    chk("t7_wr_en", pv[0], 5'b00010);
    chk("t7_data", pd[0], 32'hCAFE_F00D);

    clr();
    s_axi_awaddr = 32'h0000_F004;
    s_axi_wdata = 32'h0F0F_0F0F;
    s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid = 1'b1;
    tick(17);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
    tick(8);
    chk("t8_nhs", hs_q.size() >= 3, 1'b1);
    chk("t8_gap1", hs_q[1] - hs_q[0], 4);
    chk("t8_gap2", hs_q[2] - hs_q[1], 4);
    chk("t8_npulse", pv.size(), hs_q.size());
    chk("consec_wr_en", consec, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
